// File: rtl/elevator_pkg.sv
// Shared types and helpers for the SCAN elevator controller.
package elevator_pkg;

    // FSM state encoding
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_UP   = 3'd1,
        S_DOWN = 3'd2,
        S_DOOR = 3'd3,
        S_EMER = 3'd4
    } state_t;

    // Ceiling log2, usable in parameter/localparam expressions
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/elevator_req_tracker.sv
// Pending-request register with set/clear, plus above/below/here flags
// relative to the current floor.
module elevator_req_tracker
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS = 8,
    parameter int FLOOR_W    = clog2(NUM_FLOORS)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic [NUM_FLOORS-1:0] clear,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  above,
    output logic                  below,
    output logic                  here
);

    // Latch new requests; a clear on the same bit wins so a served floor stays served
    always_ff @(posedge clk) begin
        if (!reset_n) pending <= '0;
        else          pending <= (pending | floor_req) & ~clear;
    end

    // Direction flags only look at registered requests
    always_comb begin
        above = 1'b0;
        below = 1'b0;
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (i > int'(current_floor))) above = 1'b1;
            if (pending[i] && (i < int'(current_floor))) below = 1'b1;
        end
        here = pending[current_floor];
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// N-floor elevator controller using SCAN scheduling: keeps serving requests
// in the current direction before reversing, with per-floor travel time,
// door dwell and an emergency stop that overrides everything but reset.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int NUM_FLOORS    = 8,
    parameter int FLOOR_W       = clog2(NUM_FLOORS),
    parameter int TRAVEL_CYCLES = 4,
    parameter int DOOR_CYCLES   = 8
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [NUM_FLOORS-1:0] floor_req,
    input  logic                  emergency_stop,
    output logic                  move_up,
    output logic                  move_down,
    output logic                  motor_stop,
    output logic                  door_open,
    output logic [FLOOR_W-1:0]    current_floor,
    output logic [NUM_FLOORS-1:0] pending
);

    // Counters sized to hold their terminal value even when the cycle count is 1
    localparam int TW = clog2(TRAVEL_CYCLES + 1);
    localparam int DW = clog2(DOOR_CYCLES + 1);
    localparam logic [TW-1:0]      TRAVEL_LAST = TW'(TRAVEL_CYCLES - 1);
    localparam logic [DW-1:0]      DOOR_LAST   = DW'(DOOR_CYCLES - 1);
    localparam logic [FLOOR_W-1:0] TOP_FLOOR   = FLOOR_W'(NUM_FLOORS - 1);

    state_t                  state;
    logic                    dir_up;
    logic [TW-1:0]           travel_cnt;
    logic [DW-1:0]           door_cnt;
    logic                    above, below, here;
    logic [NUM_FLOORS-1:0]   clear;
    logic                    step;
    logic [FLOOR_W-1:0]      floor_up, floor_dn;

    assign step     = (travel_cnt == TRAVEL_LAST);
    assign floor_up = current_floor + FLOOR_W'(1);
    assign floor_dn = current_floor - FLOOR_W'(1);

    elevator_req_tracker #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_req (
        .clk           (clk),
        .reset_n       (reset_n),
        .floor_req     (floor_req),
        .clear         (clear),
        .current_floor (current_floor),
        .pending       (pending),
        .above         (above),
        .below         (below),
        .here          (here)
    );

    // Which pending bit the FSM consumes this edge; also swallows a re-press
    // of the open floor so it restarts the door instead of queuing a revisit
    always_comb begin
        clear = '0;
        if (reset_n && !emergency_stop) begin
            case (state)
                S_IDLE: if (here) clear[current_floor] = 1'b1;
                S_UP:   if (step && pending[floor_up]) clear[floor_up] = 1'b1;
                S_DOWN: if (step && pending[floor_dn]) clear[floor_dn] = 1'b1;
                S_DOOR: if (floor_req[current_floor]) clear[current_floor] = 1'b1;
                default: clear = '0;
            endcase
        end
    end

    // Main FSM: reset > emergency stop > scheduling policy
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            current_floor <= '0;
            dir_up        <= 1'b1;
            travel_cnt    <= '0;
            door_cnt      <= '0;
        end else if (emergency_stop) begin
            // Partial travel is discarded; floor and requests are kept
            state      <= S_EMER;
            travel_cnt <= '0;
            door_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    travel_cnt <= '0;
                    door_cnt   <= '0;
                    if (here)                 state <= S_DOOR;
                    else if (dir_up && above)  state <= S_UP;
                    else if (!dir_up && below) state <= S_DOWN;
                    else if (above) begin
                        state  <= S_UP;
                        dir_up <= 1'b1;
                    end else if (below) begin
                        state  <= S_DOWN;
                        dir_up <= 1'b0;
                    end
                end
                S_UP: begin
                    if (step) begin
                        travel_cnt    <= '0;
                        current_floor <= floor_up;
                        if (pending[floor_up]) state <= S_DOOR;
                    end else begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end
                end
                S_DOWN: begin
                    if (step) begin
                        travel_cnt    <= '0;
                        current_floor <= floor_dn;
                        if (pending[floor_dn]) state <= S_DOOR;
                    end else begin
                        travel_cnt <= travel_cnt + 1'b1;
                    end
                end
                S_DOOR: begin
                    if (floor_req[current_floor]) begin
                        door_cnt <= '0;
                    end else if (door_cnt == DOOR_LAST) begin
                        door_cnt <= '0;
                        state    <= S_IDLE;
                    end else begin
                        door_cnt <= door_cnt + 1'b1;
                    end
                end
                S_EMER:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Moore outputs straight from the state register
    assign move_up    = (state == S_UP);
    assign move_down  = (state == S_DOWN);
    assign door_open  = (state == S_DOOR);
    assign motor_stop = (state == S_IDLE) || (state == S_DOOR) || (state == S_EMER);

    // The policy must never step off either end of the shaft
    a_no_step_past_top: assert property (@(posedge clk) disable iff (!reset_n)
        (!emergency_stop && state == S_UP && step) |-> (current_floor != TOP_FLOOR));
    a_no_step_past_bottom: assert property (@(posedge clk) disable iff (!reset_n)
        (!emergency_stop && state == S_DOWN && step) |-> (current_floor != '0));

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl (8 floors, 4-cycle travel, 8-cycle door).
// Inputs change and outputs are sampled on the falling edge; "cycle c" is the
// interval after rising edge c.
module tb_elevator_scan_ctrl;

    logic       clk;
    logic       reset_n;
    logic [7:0] floor_req;
    logic       emergency_stop;
    logic       move_up, move_down, motor_stop, door_open;
    logic [2:0] current_floor;
    logic [7:0] pending;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;

    elevator_scan_ctrl #(
        .NUM_FLOORS    (8),
        .FLOOR_W       (3),
        .TRAVEL_CYCLES (4),
        .DOOR_CYCLES   (8)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .floor_req      (floor_req),
        .emergency_stop (emergency_stop),
        .move_up        (move_up),
        .move_down      (move_down),
        .motor_stop     (motor_stop),
        .door_open      (door_open),
        .current_floor  (current_floor),
        .pending        (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic at(input int c);
        while (cyc < c) tick(1);
    endtask

    logic [7:0] exp_p;
    logic [7:0] all_ones;

    initial begin
        reset_n        = 1'b0;
        floor_req      = '0;
        emergency_stop = 1'b0;
        all_ones       = 8'hFF;
        tick(2);
        chk("rst motor_stop", motor_stop, 1);
        chk("rst move_up", move_up, 0);
        chk("rst move_down", move_down, 0);
        chk("rst door_open", door_open, 0);
        chk("rst floor", current_floor, 0);
        chk("rst pending", pending, 0);

        // 1: single request for floor 2
        cyc       = 0;
        reset_n   = 1'b1;
        floor_req = 8'h04;
        tick(1);
        floor_req = '0;
        chk("t1 pending latched", pending, 8'h04);
        chk("t1 c1 idle", motor_stop, 1);
        for (int c = 2; c <= 17; c++) begin
            at(c);
            chk($sformatf("t1 move_up c%0d", c), move_up, (c <= 9) ? 1 : 0);
            chk($sformatf("t1 door c%0d", c), door_open, (c >= 10) ? 1 : 0);
            chk($sformatf("t1 floor c%0d", c), current_floor, (c < 6) ? 0 : (c < 10) ? 1 : 2);
        end
        at(10);
        at(18);
        chk("t1 idle door", door_open, 0);
        chk("t1 idle stop", motor_stop, 1);
        chk("t1 pending clear", pending, 0);

        // 2: at floor 2 heading up, requests for 5 and 0
        floor_req = 8'h21;
        at(19);
        floor_req = '0;
        chk("t2 pending", pending, 8'h21);
        at(28);
        chk("t2 passes 4 floor", current_floor, 4);
        chk("t2 passes 4 moving", move_up, 1);
        at(32);
        chk("t2 door at 5", door_open, 1);
        chk("t2 floor 5", current_floor, 5);
        chk("t2 pending 0 left", pending, 8'h01);
        at(41);
        chk("t2 reverse down", move_down, 1);
        at(57);
        chk("t2 floor 1 moving", current_floor, 1);
        at(61);
        chk("t2 door at 0", door_open, 1);
        chk("t2 floor 0", current_floor, 0);
        chk("t2 pending empty", pending, 0);
        at(69);
        chk("t2 idle", motor_stop, 1);

        // 3: emergency stop mid-travel 3->4
        floor_req = 8'h10;
        at(70);
        floor_req = '0;
        at(83);
        chk("t3 floor 3 moving", move_up, 1);
        chk("t3 at 3", current_floor, 3);
        at(84);
        emergency_stop = 1'b1;
        at(85);
        chk("t3 emer move_up", move_up, 0);
        chk("t3 emer stop", motor_stop, 1);
        chk("t3 emer floor", current_floor, 3);
        chk("t3 emer pending", pending, 8'h10);
        at(86);
        emergency_stop = 1'b0;
        chk("t3 emer held", move_up, 0);
        at(87);
        chk("t3 idle after emer", motor_stop, 1);
        chk("t3 idle no move", move_up, 0);
        at(88);
        chk("t3 resume up", move_up, 1);
        at(91);
        chk("t3 full travel floor", current_floor, 3);
        chk("t3 full travel move", move_up, 1);
        at(92);
        chk("t3 door at 4", door_open, 1);
        chk("t3 floor 4", current_floor, 4);
        chk("t3 pending cleared", pending, 0);

        // 4: re-press of the open floor restarts the door
        at(100);
        floor_req = 8'h40;
        at(101);
        floor_req = '0;
        at(110);
        chk("t4 door at 6", door_open, 1);
        chk("t4 floor 6", current_floor, 6);
        at(115);
        floor_req = 8'h40;
        at(116);
        floor_req = '0;
        chk("t4 repress not latched", pending, 0);
        chk("t4 door still open", door_open, 1);
        at(118);
        chk("t4 door extended", door_open, 1);
        at(123);
        chk("t4 door last cycle", door_open, 1);
        chk("t4 pending stays 0", pending, 0);
        at(124);
        chk("t4 door closed", door_open, 0);
        chk("t4 idle", motor_stop, 1);

        // 5: reset while moving down with requests outstanding
        floor_req = 8'h03;
        at(125);
        floor_req = '0;
        at(127);
        chk("t5 moving down", move_down, 1);
        chk("t5 pending", pending, 8'h03);
        reset_n = 1'b0;
        at(128);
        chk("t5 rst stop", motor_stop, 1);
        chk("t5 rst move_down", move_down, 0);
        chk("t5 rst door", door_open, 0);
        chk("t5 rst floor", current_floor, 0);
        chk("t5 rst pending", pending, 0);

        // 6: every floor requested at once from floor 0 (asserted for one cycle)
        reset_n   = 1'b1;
        floor_req = 8'hFF;
        at(129);
        floor_req = '0;
        chk("t6 pending all", pending, 8'hFF);
        at(130);
        chk("t6 door at 0", door_open, 1);
        chk("t6 pending after 0", pending, 8'hFE);
        for (int f = 1; f <= 7; f++) begin
            at(130 + 13 * f - 1);
            chk($sformatf("t6 moving to %0d", f), move_up, 1);
            at(130 + 13 * f);
            exp_p = all_ones << (f + 1);
            chk($sformatf("t6 door at %0d", f), door_open, 1);
            chk($sformatf("t6 floor %0d", f), current_floor, f);
            chk($sformatf("t6 pending at %0d", f), pending, exp_p);
        end
        at(235);
        chk("t6 final idle", motor_stop, 1);
        chk("t6 final floor", current_floor, 7);
        chk("t6 final no move", move_up, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
